// File: rtl/accum_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : accum_sequencer                                              |
// | Description : Slice-serial accumulate controller driving one shared        |
// |               external SLICE-bit adder; Run edge adds latched A_In.        |
// |               Optional macro SEQ_SHADOW_OUT_EN: Acc_Out from a shadow      |
// |               register updated only when an accumulate completes.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module accum_sequencer #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             Clear,
  input  logic [WIDTH-1:0] A_In,
  output logic [SLICE-1:0] Slice_A,
  output logic [SLICE-1:0] Slice_B,
  output logic             Slice_Cin,
  input  logic [SLICE-1:0] Slice_S,
  input  logic             Slice_Cout,
  output logic [WIDTH:0]   Acc_Out,
  output logic             Busy,
  output logic             Done
);

  localparam int N    = WIDTH / SLICE;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] c_last_idx = IDXW'(N - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ADD      = 2'd1;
  localparam logic [1:0] S_DONE     = 2'd2;
  localparam logic [1:0] S_WAIT_REL = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic             r_run_prev;
  logic [WIDTH-1:0] r_op;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH:0]   w_acc_next;
  logic             w_run_rise;
  logic             w_last;

  assign w_run_rise = Run & ~r_run_prev;
  assign w_last     = (r_idx == c_last_idx);

  // Working accumulator with the current slice's sum merged in; carry bit only
  // changes on the final slice so a new add overwrites the previous carry.
  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[r_idx*SLICE +: SLICE] = Slice_S;
    if (w_last) begin
      w_acc_next[WIDTH] = Slice_Cout;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (Clear) begin
      w_state_next = Run ? S_WAIT_REL : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (w_run_rise) w_state_next = S_ADD;
        S_ADD:      if (w_last) w_state_next = S_DONE;
        S_DONE:     w_state_next = Run ? S_WAIT_REL : S_IDLE;
        S_WAIT_REL: if (!Run) w_state_next = S_IDLE;
        default:    w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    Busy      = 1'b0;
    Done      = 1'b0;
    Slice_A   = '0;
    Slice_B   = '0;
    Slice_Cin = 1'b0;
    case (r_state)
      S_ADD: begin
        Busy      = 1'b1;
        Slice_A   = r_op[r_idx*SLICE +: SLICE];
        Slice_B   = r_acc[r_idx*SLICE +: SLICE];
        Slice_Cin = r_carry;
      end
      S_DONE:  Done = ~Clear;
      default: ;
    endcase
  end

  // Reset leaves run_prev high so a Run held through reset is not an edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_run_prev <= 1'b1;
      r_op       <= '0;
      r_acc      <= '0;
    end else begin
      r_run_prev <= Run;
      if (Clear) begin
        r_acc   <= '0;
        r_carry <= 1'b0;
        r_idx   <= '0;
      end else if (r_state == S_IDLE && w_run_rise) begin
        r_op    <= A_In;
        r_carry <= 1'b0;
        r_idx   <= '0;
      end else if (r_state == S_ADD) begin
        r_acc   <= w_acc_next;
        r_carry <= Slice_Cout;
        r_idx   <= w_last ? '0 : r_idx + 1'b1;
      end
    end
  end

`ifdef SEQ_SHADOW_OUT_EN
  logic [WIDTH:0] r_shadow;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_shadow <= '0;
    end else if (Clear) begin
      r_shadow <= '0;
    end else if (r_state == S_ADD && w_last) begin
      r_shadow <= w_acc_next;
    end
  end

  assign Acc_Out = r_shadow;
`else
  assign Acc_Out = r_acc;
`endif

endmodule
`default_nettype wire
